// File: rtl/lock_pkg.sv
// Shared types and constants for the canal-lock sequencer.
package lock_pkg;

    localparam int CNT_W           = 4;
    localparam int DEF_FILL_TICKS  = 7;
    localparam int DEF_DRAIN_TICKS = 8;
    localparam int DEF_WAIT_TICKS  = 5;

    typedef enum logic [2:0] {
        LOW_IDLE,
        HIGH_IDLE,
        ENTER,
        FILL,
        DRAIN,
        EXIT
    } state_t;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } level_t;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter that steps on tick and parks at zero; load beats tick.
module tick_down_counter
    import lock_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lock_controller.sv
// Canal-lock chamber sequencer: latches arrivals, runs enter/fill/drain/exit
// countdowns and drives gates plus the display-stage flags and values.
module lock_controller
    import lock_pkg::*;
#(
    parameter int FILL_TICKS  = DEF_FILL_TICKS,
    parameter int DRAIN_TICKS = DEF_DRAIN_TICKS,
    parameter int WAIT_TICKS  = DEF_WAIT_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             arrive_low,
    input  logic             arrive_high,
    output logic             gate_low_open,
    output logic             gate_high_open,
    output logic             draining,
    output logic             filling,
    output logic             waiting,
    output logic [CNT_W-1:0] drainVal,
    output logic [CNT_W-1:0] fillVal,
    output logic [CNT_W-1:0] waitVal,
    output logic             busy
);

    // The downstream display only decodes digits 0..8.
    if (FILL_TICKS < 1 || FILL_TICKS > 8)
        $error("lock_controller: FILL_TICKS must be in 1..8");
    if (DRAIN_TICKS < 1 || DRAIN_TICKS > 8)
        $error("lock_controller: DRAIN_TICKS must be in 1..8");
    if (WAIT_TICKS < 1 || WAIT_TICKS > 8)
        $error("lock_controller: WAIT_TICKS must be in 1..8");

    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_TICKS);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_TICKS);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_TICKS);

    state_t           state, state_nxt;
    level_t           level, level_nxt;
    logic             carry, carry_nxt;
    logic             pend_low, pend_high;
    logic             clr_low, clr_high;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             zero;
    logic             done;

    tick_down_counter u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .cnt      (cnt),
        .zero     (zero)
    );

    assign done = tick & zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOW_IDLE;
            level     <= LOW;
            carry     <= 1'b0;
            pend_low  <= 1'b0;
            pend_high <= 1'b0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            carry     <= carry_nxt;
            // A new arrival on the same cycle as the clear keeps the flag set.
            pend_low  <= arrive_low  | (pend_low  & ~clr_low);
            pend_high <= arrive_high | (pend_high & ~clr_high);
        end
    end

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        carry_nxt = carry;
        load      = 1'b0;
        load_val  = '0;
        clr_low   = 1'b0;
        clr_high  = 1'b0;
        case (state)
            LOW_IDLE: begin
                if (pend_low) begin
                    state_nxt = ENTER;
                    carry_nxt = 1'b1;
                    load      = 1'b1;
                    load_val  = WAIT_LD;
                    clr_low   = 1'b1;
                end else if (pend_high) begin
                    state_nxt = FILL;
                    carry_nxt = 1'b0;
                    load      = 1'b1;
                    load_val  = FILL_LD;
                end
            end
            HIGH_IDLE: begin
                if (pend_high) begin
                    state_nxt = ENTER;
                    carry_nxt = 1'b1;
                    load      = 1'b1;
                    load_val  = WAIT_LD;
                    clr_high  = 1'b1;
                end else if (pend_low) begin
                    state_nxt = DRAIN;
                    carry_nxt = 1'b0;
                    load      = 1'b1;
                    load_val  = DRAIN_LD;
                end
            end
            ENTER: begin
                if (done) begin
                    load = 1'b1;
                    if (level == LOW) begin
                        state_nxt = FILL;
                        load_val  = FILL_LD;
                    end else begin
                        state_nxt = DRAIN;
                        load_val  = DRAIN_LD;
                    end
                end
            end
            FILL: begin
                if (done) begin
                    level_nxt = HIGH;
                    if (carry) begin
                        state_nxt = EXIT;
                        load      = 1'b1;
                        load_val  = WAIT_LD;
                    end else begin
                        state_nxt = HIGH_IDLE;
                    end
                end
            end
            DRAIN: begin
                if (done) begin
                    level_nxt = LOW;
                    if (carry) begin
                        state_nxt = EXIT;
                        load      = 1'b1;
                        load_val  = WAIT_LD;
                    end else begin
                        state_nxt = LOW_IDLE;
                    end
                end
            end
            EXIT: begin
                if (done) begin
                    carry_nxt = 1'b0;
                    state_nxt = (level == LOW) ? LOW_IDLE : HIGH_IDLE;
                end
            end
            default: state_nxt = LOW_IDLE;
        endcase
    end

    // Outputs decode flops only, so they move on the same edge as state/cnt.
    assign busy           = !((state == LOW_IDLE) || (state == HIGH_IDLE));
    assign gate_low_open  = (level == LOW) &&
                            ((state == LOW_IDLE) || (state == ENTER) || (state == EXIT));
    assign gate_high_open = (level == HIGH) &&
                            ((state == HIGH_IDLE) || (state == ENTER) || (state == EXIT));
    assign waiting        = (state == ENTER) || (state == EXIT);
    assign filling        = (state == FILL);
    assign draining       = (state == DRAIN);
    assign waitVal        = waiting  ? cnt : '0;
    assign fillVal        = filling  ? cnt : '0;
    assign drainVal       = draining ? cnt : '0;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with default tick parameters.
module tb_lock_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       arrive_low;
    logic       arrive_high;
    logic       gate_low_open;
    logic       gate_high_open;
    logic       draining;
    logic       filling;
    logic       waiting;
    logic [3:0] drainVal;
    logic [3:0] fillVal;
    logic [3:0] waitVal;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int ph       = 0;
    bit sparse   = 1'b0;

    lock_controller dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .arrive_low     (arrive_low),
        .arrive_high    (arrive_high),
        .gate_low_open  (gate_low_open),
        .gate_high_open (gate_high_open),
        .draining       (draining),
        .filling        (filling),
        .waiting        (waiting),
        .drainVal       (drainVal),
        .fillVal        (fillVal),
        .waitVal        (waitVal),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {gate_low_open, gate_high_open, draining, filling, waiting, busy,
                  drainVal, fillVal, waitVal};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%05h expected=%05h", tag, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic gl, input logic gh,
                              input logic dr, input logic fi, input logic wa,
                              input logic bz, input int dv, input int fv, input int wv);
        logic [17:0] e;
        e = {gl, gh, dr, fi, wa, bz, 4'(dv), 4'(fv), 4'(wv)};
        chk(tag, 32'(obs), 32'(e));
    endtask

    task automatic exp_low_idle(input string tag);
        expect_out(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic exp_high_idle(input string tag);
        expect_out(tag, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic exp_wait_low(input string tag, input int v);
        expect_out(tag, 1, 0, 0, 0, 1, 1, 0, 0, v);
    endtask
    task automatic exp_wait_high(input string tag, input int v);
        expect_out(tag, 0, 1, 0, 0, 1, 1, 0, 0, v);
    endtask
    task automatic exp_fill(input string tag, input int v);
        expect_out(tag, 0, 0, 0, 1, 0, 1, 0, v, 0);
    endtask
    task automatic exp_drain(input string tag, input int v);
        expect_out(tag, 0, 0, 1, 0, 0, 1, v, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (sparse) begin
            ph++;
            tick = (ph % 4 == 1);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        arrive_low  = 1'b0;
        arrive_high = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Starts on the first ENTER sample at the low level (tick held high),
    // ends on the first HIGH_IDLE sample.
    task automatic run_up(input int hi_pulse_at);
        for (int v = 5; v >= 0; v--) begin
            exp_wait_low("enter_low", v);
            step();
        end
        for (int v = 7; v >= 0; v--) begin
            exp_fill("fill", v);
            if (v == hi_pulse_at) arrive_high = 1'b1;
            step();
            arrive_high = 1'b0;
        end
        for (int v = 5; v >= 0; v--) begin
            exp_wait_high("exit_high", v);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        tick        = 1'b0;
        arrive_low  = 1'b0;
        arrive_high = 1'b0;
        #2;
        exp_low_idle("reset_async");
        step();
        step();
        reset = 1'b0;
        step();
        exp_low_idle("idle_after_reset");

        // Full low-to-high service with tick stuck high.
        tick       = 1'b1;
        arrive_low = 1'b1;
        step();
        arrive_low = 1'b0;
        exp_low_idle("latch_low");
        step();
        run_up(-1);
        exp_high_idle("up_done");

        // Empty drain from HIGH_IDLE, then the still-pending low boat enters.
        arrive_low = 1'b1;
        step();
        arrive_low = 1'b0;
        exp_high_idle("latch_low_hi");
        step();
        for (int v = 8; v >= 0; v--) begin
            exp_drain("empty_drain", v);
            step();
        end
        exp_low_idle("drain_done");
        step();
        exp_wait_low("enter_after_drain", 5);

        // Simultaneous arrivals: low served first, high held.
        do_reset();
        arrive_low  = 1'b1;
        arrive_high = 1'b1;
        step();
        arrive_low  = 1'b0;
        arrive_high = 1'b0;
        step();
        run_up(-1);
        exp_high_idle("both_hi_idle");
        step();
        exp_wait_high("both_high_enter", 5);

        // High arrival in the middle of FILL is not lost.
        do_reset();
        arrive_low = 1'b1;
        step();
        arrive_low = 1'b0;
        step();
        run_up(4);
        exp_high_idle("midfill_hi_idle");
        step();
        exp_wait_high("midfill_high_enter", 5);

        // Asynchronous reset mid-FILL drops the phase and pending requests.
        do_reset();
        arrive_low = 1'b1;
        step();
        arrive_low = 1'b0;
        step();
        repeat (8) step();
        exp_fill("pre_reset_fill", 5);
        arrive_high = 1'b1;
        step();
        arrive_high = 1'b0;
        exp_fill("pre_reset_fill4", 4);
        reset = 1'b1;
        #1;
        exp_low_idle("async_reset_midfill");
        #1;
        reset = 1'b0;
        step();
        step();
        exp_low_idle("pend_discarded");

        // Sparse tick, one pulse every 4 clocks, coincident with ENTER entry.
        tick       = 1'b0;
        ph         = 0;
        sparse     = 1'b1;
        arrive_low = 1'b1;
        step();
        arrive_low = 1'b0;
        step();
        for (int v = 5; v >= 0; v--) begin
            for (int k = 0; k < 4; k++) begin
                exp_wait_low("sparse_enter", v);
                step();
            end
        end
        for (int k = 0; k < 4; k++) begin
            exp_fill("sparse_fill7", 7);
            step();
        end
        exp_fill("sparse_fill6", 6);
        sparse = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
